prach_hb5_split: RTL and testbench

PRACH_HB5_SPLIT -- requirements
Module: prach_hb5_split

---
 rtl/prach_hb5_split.sv | 124 ++++++++++++
 tb/tb_prach_hb5_split.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_hb5_split.sv
// prach_hb5_split: splits a TDM multi-channel sample stream into per-channel polyphase pairs
// for a half-band decimator; 2-cycle latency, sticky orphan detection on frame start. Rev 1.0
`default_nettype none

module prach_hb5_split #(
   parameter int DW = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din_dq,
   input  logic          din_dv,
   input  logic [CW-1:0] din_chn,
   input  logic          sync_in,
   input  logic          err_clr,
   output logic [DW-1:0] dout_dp1,
   output logic [DW-1:0] dout_dp2,
   output logic          dout_dv,
   output logic [CW-1:0] dout_chn,
   output logic          sync_out,
   output logic          orphan_err
);

   localparam int NCH = 1 << CW;

   logic [NCH-1:0] r_phase;
   logic [DW-1:0]  r_ram [NCH];

   logic           r_wr_vld;
   logic [CW-1:0]  r_wr_chn;
   logic [DW-1:0]  r_wr_dq;

   logic           r1_dv;
   logic           r1_sync;
   logic [CW-1:0]  r1_chn;
   logic [DW-1:0]  r1_dp1;
   logic [DW-1:0]  r1_dp2;

   logic           w_ph_cur;
   logic           w_pair;
   logic           w_wr;
   logic           w_byp;
   logic           w_orph_set;
   logic [NCH-1:0] w_phase_nxt;

   // Frame start clears every phase bit before the coincident sample is looked at.
   always_comb begin
      w_ph_cur    = sync_in ? 1'b0 : r_phase[din_chn];
      w_pair      = din_dv & w_ph_cur;
      w_wr        = din_dv & ~w_ph_cur;
      w_byp       = r_wr_vld && (r_wr_chn == din_chn);
      w_orph_set  = sync_in & (|r_phase);
      w_phase_nxt = sync_in ? '0 : r_phase;
      if (din_dv) begin
         w_phase_nxt[din_chn] = ~w_ph_cur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase  <= '0;
         r_wr_vld <= 1'b0;
      end else begin
         r_phase  <= w_phase_nxt;
         r_wr_vld <= w_wr;
      end
   end

   // RAM write is registered one cycle, so a back-to-back read of the same channel
   // must take the pending write data instead of the stale array entry.
   always_ff @(posedge clk) begin
      r_wr_chn <= din_chn;
      r_wr_dq  <= din_dq;
      if (r_wr_vld) begin
         r_ram[r_wr_chn] <= r_wr_dq;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_dv   <= 1'b0;
         r1_sync <= 1'b0;
         r1_chn  <= '0;
         r1_dp1  <= '0;
         r1_dp2  <= '0;
      end else begin
         r1_dv   <= w_pair;
         r1_sync <= sync_in;
         r1_chn  <= din_chn;
         r1_dp1  <= din_dq;
         r1_dp2  <= w_byp ? r_wr_dq : r_ram[din_chn];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_dv  <= 1'b0;
         sync_out <= 1'b0;
         dout_chn <= '0;
         dout_dp1 <= '0;
         dout_dp2 <= '0;
      end else begin
         dout_dv  <= r1_dv;
         sync_out <= r1_sync;
         dout_chn <= r1_dv ? r1_chn : '0;
         dout_dp1 <= r1_dv ? r1_dp1 : '0;
         dout_dp2 <= r1_dv ? r1_dp2 : '0;
      end
   end

   // Set has priority over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         orphan_err <= 1'b0;
      end else if (w_orph_set) begin
         orphan_err <= 1'b1;
      end else if (err_clr) begin
         orphan_err <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prach_hb5_split.sv
// tb_prach_hb5_split: scoreboard bench with a per-channel pairing model for prach_hb5_split. Rev 1.0
`default_nettype none

module tb_prach_hb5_split;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din_dq;
   logic        din_dv;
   logic [7:0]  din_chn;
   logic        sync_in;
   logic        err_clr;
   logic [15:0] dout_dp1;
   logic [15:0] dout_dp2;
   logic        dout_dv;
   logic [7:0]  dout_chn;
   logic        sync_out;
   logic        orphan_err;

   prach_hb5_split #(.DW(16), .CW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din_dq    (din_dq),
      .din_dv    (din_dv),
      .din_chn   (din_chn),
      .sync_in   (sync_in),
      .err_clr   (err_clr),
      .dout_dp1  (dout_dp1),
      .dout_dp2  (dout_dp2),
      .dout_dv   (dout_dv),
      .dout_chn  (dout_chn),
      .sync_out  (sync_out),
      .orphan_err(orphan_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          chn;
      logic [15:0] dp1;
      logic [15:0] dp2;
      int          due;
   } pair_t;

   pair_t       q_pair[$];
   int          q_sync[$];
   int          cyc = 0;
   int          ntest = 0;
   int          nfail = 0;
   int          npairs = 0;
   bit          exp_orph = 1'b0;

   // Reference model: which channels hold an unpaired sample, and that sample.
   bit          m_held [256];
   logic [15:0] m_samp [256];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         bit    es;
         pair_t p;
         es = 1'b0;
         if (q_sync.size() > 0 && q_sync[0] == cyc) begin
            es = 1'b1;
            void'(q_sync.pop_front());
         end
         ntest++;
         if (sync_out !== es) begin
            nfail++;
            $display("FAIL sync_out cyc=%0d got=%b exp=%b", cyc, sync_out, es);
         end
         ntest++;
         if (orphan_err !== exp_orph) begin
            nfail++;
            $display("FAIL orphan_err cyc=%0d got=%b exp=%b", cyc, orphan_err, exp_orph);
         end
         if (dout_dv !== 1'b0) begin
            npairs++;
            ntest++;
            if (q_pair.size() == 0) begin
               nfail++;
               $display("FAIL pair_unexpected cyc=%0d dv=%b chn=%0d dp1=%h dp2=%h exp=none",
                        cyc, dout_dv, dout_chn, dout_dp1, dout_dp2);
            end else begin
               p = q_pair.pop_front();
               if (dout_dv !== 1'b1 || dout_chn !== p.chn[7:0] || dout_dp1 !== p.dp1 ||
                   dout_dp2 !== p.dp2 || cyc != p.due) begin
                  nfail++;
                  $display("FAIL pair cyc=%0d got chn=%0d dp1=%h dp2=%h exp chn=%0d dp1=%h dp2=%h due=%0d",
                           cyc, dout_chn, dout_dp1, dout_dp2, p.chn, p.dp1, p.dp2, p.due);
               end
            end
         end
      end
   end

   task automatic step(input bit dv, input int chn, input logic [15:0] dq,
                       input bit sy, input bit clr);
      bit    nxt_orph;
      bit    any_held;
      pair_t p;
      din_dv  = dv;
      din_chn = chn[7:0];
      din_dq  = dq;
      sync_in = sy;
      err_clr = clr;
      any_held = 1'b0;
      for (int i = 0; i < 256; i++) any_held |= m_held[i];
      nxt_orph = (sy && any_held) ? 1'b1 : (clr ? 1'b0 : exp_orph);
      if (sy) begin
         for (int i = 0; i < 256; i++) m_held[i] = 1'b0;
         q_sync.push_back(cyc + 2);
      end
      if (dv) begin
         if (m_held[chn]) begin
            p.chn = chn; p.dp1 = dq; p.dp2 = m_samp[chn]; p.due = cyc + 2;
            q_pair.push_back(p);
            m_held[chn] = 1'b0;
         end else begin
            m_samp[chn] = dq;
            m_held[chn] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      exp_orph = nxt_orph;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      ntest++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_dout_dv", {15'b0, dout_dv}, 16'h0);
      chk("rst_sync_out", {15'b0, sync_out}, 16'h0);
      chk("rst_orphan_err", {15'b0, orphan_err}, 16'h0);
      chk("rst_dout_chn", {8'b0, dout_chn}, 16'h0);
      chk("rst_dout_dp1", dout_dp1, 16'h0);
      chk("rst_dout_dp2", dout_dp2, 16'h0);
      for (int i = 0; i < 256; i++) m_held[i] = 1'b0;
      exp_orph = 1'b0;
      q_sync.delete();
      q_pair.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      rst_n = 1'b0; din_dv = 1'b0; din_chn = '0; din_dq = '0; sync_in = 1'b0; err_clr = 1'b0;
      for (int i = 0; i < 256; i++) begin m_held[i] = 1'b0; m_samp[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // ch 5, non-consecutive
      step(1, 5, 16'h1111, 0, 0);
      idle(3);
      step(1, 5, 16'h2222, 0, 0);
      idle(3);

      // ch 7 back-to-back (bypass)
      step(1, 7, 16'h0A0A, 0, 0);
      step(1, 7, 16'h0B0B, 0, 0);
      idle(3);

      // 48 channels interleaved with gaps
      p0 = npairs;
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 48; c++) begin
            step(1, 100 + c, 16'($urandom), 0, 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      idle(4);
      chk("pairs48_count", 16'(npairs - p0), 16'd48);

      // orphan on ch 3 then clear
      step(1, 3, 16'h1234, 0, 0);
      idle(1);
      step(1, 3, 16'h7FFF, 1, 0);
      step(1, 3, 16'h8000, 0, 0);
      idle(3);
      chk("orphan_set", {15'b0, orphan_err}, 16'h1);
      step(0, 0, 16'h0, 0, 1);
      idle(1);
      chk("orphan_clr", {15'b0, orphan_err}, 16'h0);

      // set wins over simultaneous clear
      step(1, 20, 16'h5555, 0, 0);
      step(0, 0, 16'h0, 1, 1);
      idle(1);
      chk("orphan_set_wins", {15'b0, orphan_err}, 16'h1);
      step(0, 0, 16'h0, 0, 1);

      // reset mid-pair on ch 9
      step(1, 9, 16'hDEAD, 0, 0);
      idle(3);
      do_reset();
      step(1, 9, 16'h0123, 0, 0);
      step(1, 9, 16'h4567, 0, 0);
      idle(3);

      // sync with no data
      step(0, 0, 16'h0, 1, 0);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15), 16'($urandom),
              $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
      end
      idle(4);

      ntest++;
      if (q_pair.size() != 0 || q_sync.size() != 0) begin
         nfail++;
         $display("FAIL drain pairs_left=%0d syncs_left=%0d exp=0", q_pair.size(), q_sync.size());
      end
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule

`default_nettype wire
